// File: rtl/mul_pipe_param_if.sv
// Valid/ready operand and result channels of the pipelined multiplier.
// The master drives operands and consumes results; the slave is the multiplier.
interface mul_pipe_param_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] r;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, a, b, is_signed, in_tag, out_ready,
    input  in_ready, out_valid, r, out_tag
  );

  modport slave (
    input  in_valid, a, b, is_signed, in_tag, out_ready,
    output in_ready, out_valid, r, out_tag
  );
endinterface

// File: rtl/mul_pipe_param.sv
// Two-stage signed/unsigned multiplier: stage 1 registers magnitude partial
// products per DIGIT-wide multiplier slice, stage 2 sums them and applies the sign.
module mul_pipe_param #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mul_pipe_param_if.slave bus
);
  localparam int NS = WIDTH / DIGIT;

  if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_params
    $error("mul_pipe_param: WIDTH must be a positive multiple of DIGIT");
  end

  logic                   adv;
  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;
  logic                   in_neg;

  logic                   s1_valid;
  logic                   s1_neg;
  logic [TAG_W-1:0]       s1_tag;
  logic [WIDTH+DIGIT-1:0] s1_pp [NS];

  logic [2*WIDTH-1:0]     sum;
  logic                   s2_valid;
  logic [2*WIDTH-1:0]     s2_r;
  logic [TAG_W-1:0]       s2_tag;

  assign adv          = !s2_valid | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = s2_valid;
  assign bus.r         = s2_r;
  assign bus.out_tag   = s2_tag;

  // Magnitudes stay WIDTH bits: negating the most-negative value yields 2^(WIDTH-1) unsigned.
  assign mag_a  = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
  assign mag_b  = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  assign in_neg = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (adv && bus.in_valid) begin
      s1_neg <= in_neg;
      s1_tag <= bus.in_tag;
      for (int k = 0; k < NS; k++) begin
        s1_pp[k] <= {{DIGIT{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b[k*DIGIT +: DIGIT]};
      end
    end
  end

  always_comb begin
    logic [2*WIDTH-1:0] ext;
    sum = '0;
    ext = '0;
    for (int k = 0; k < NS; k++) begin
      ext = '0;
      ext[WIDTH+DIGIT-1:0] = s1_pp[k];
      sum = sum + (ext << (k*DIGIT));
    end
  end

  // Result registers are cleared so r/out_tag read 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_r   <= '0;
      s2_tag <= '0;
    end else if (adv && s1_valid) begin
      s2_r   <= s1_neg ? (~sum + 1'b1) : sum;
      s2_tag <= s1_tag;
    end
  end
endmodule

// File: tb/tb_mul_pipe_param.sv
// Scoreboard bench for mul_pipe_param (WIDTH=32, DIGIT=8, TAG_W=4): driver pushes
// expected results on acceptance, a negedge monitor pops and compares on handshake.
module tb_mul_pipe_param;
  localparam int W  = 32;
  localparam int TW = 4;

  typedef struct {
    logic [2*W-1:0] r;
    logic [TW-1:0]  tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   pops;
  exp_t sb [$];

  mul_pipe_param_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  mul_pipe_param #(.WIDTH(W), .DIGIT(8), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed at the next posedge when valid & ready at the negedge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got r=%h tag=%0d expected no result", bus.r, bus.out_tag);
      end else begin
        e = sb.pop_front();
        pops++;
        chk("result_r", bus.r, e.r);
        chk("result_tag", {{(2*W-TW){1'b0}}, bus.out_tag}, {{(2*W-TW){1'b0}}, e.tag});
      end
    end
  end

  bit stream_stall;

  // Called just after a posedge; returns just after the posedge that accepted the op.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input logic [TW-1:0] tag, input logic [2*W-1:0] exp_r);
    int budget;
    exp_t e;
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.in_tag    = tag;
    budget = 0;
    @(negedge clk);
    while (!bus.in_ready) begin
      stream_stall = 1'b1;
      budget++;
      if (budget > 50) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: in_ready stuck at 0, expected 1 within 50 cycles");
        break;
      end
      @(negedge clk);
    end
    e.r   = exp_r;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [W-1:0]   ra;
    logic [W-1:0]   rb;
    logic           rs;
    logic [2*W-1:0] hold_r;
    int             p0;
    int             budget;

    checks = 0; failures = 0; pops = 0; stream_stall = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
    bus.in_tag = '0; bus.out_ready = 1'b1;

    #12;
    chk("reset_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("reset_in_ready", {63'b0, bus.in_ready}, 64'd1);
    chk("reset_r", bus.r, 64'd0);
    chk("reset_out_tag", {60'b0, bus.out_tag}, 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Corner case plus two-register latency: invisible one edge later, valid after the second.
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd3, 64'hFFFFFFFE00000001);
    @(negedge clk);
    chk("latency_not_early", {63'b0, bus.out_valid}, 64'd0);
    @(negedge clk);
    chk("latency_valid", {63'b0, bus.out_valid}, 64'd1);
    idle(2);

    send(32'h80000000, 32'h80000000, 1'b1, 4'd4, 64'h4000000000000000);
    send(32'h80000000, 32'h80000000, 1'b0, 4'd5, 64'h4000000000000000);
    send(32'hFFFFFFFF, 32'd5, 1'b1, 4'd1, 64'hFFFFFFFFFFFFFFFB);
    send(32'hFFFFFFFF, 32'd5, 1'b0, 4'd2, 64'h00000004FFFFFFFB);
    send(32'h80000000, 32'h00000001, 1'b1, 4'd6, 64'hFFFFFFFF80000000);
    send(32'h7FFFFFFF, 32'h80000000, 1'b1, 4'd7, 64'hC000000080000000);
    send(32'd0, 32'hFFFFFFFF, 1'b1, 4'd8, 64'd0);
    send(32'h12345678, 32'h00000010, 1'b0, 4'd9, 64'h0000000123456780);
    idle(4);
    chk("directed_drained", sb.size(), 64'd0);

    // Streaming: continuous valid with a continuously ready consumer.
    stream_stall = 1'b0;
    p0 = pops;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      send(ra, rb, rs, TW'(i), model(ra, rb, rs));
    end
    idle(3);
    chk("stream_in_ready_high", {63'b0, stream_stall}, 64'd0);
    chk("stream_result_count", pops - p0, 64'd100);

    // Stall: consumer holds off for 3 cycles while a result is presented.
    bus.out_ready = 1'b0;
    send(32'd7, 32'd9, 1'b0, 4'hA, 64'd63);
    send(32'hFFFFFFFE, 32'd3, 1'b1, 4'hB, 64'hFFFFFFFFFFFFFFFA);
    budget = 0;
    @(negedge clk);
    while (!bus.out_valid && budget < 10) begin
      budget++;
      @(negedge clk);
    end
    chk("stall_valid_seen", {63'b0, bus.out_valid}, 64'd1);
    hold_r = 64'd63;
    bus.in_valid = 1'b1; bus.a = 32'hDEAD; bus.b = 32'hBEEF; bus.in_tag = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("stall_r_stable", bus.r, hold_r);
      chk("stall_tag_stable", {60'b0, bus.out_tag}, 64'hA);
      chk("stall_in_ready_low", {63'b0, bus.in_ready}, 64'd0);
      chk("stall_valid_stable", {63'b0, bus.out_valid}, 64'd1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    idle(4);
    chk("stall_drained", sb.size(), 64'd0);

    // Reset with two operations in flight, asserted between clock edges.
    send(32'd11, 32'd13, 1'b0, 4'h1, 64'd143);
    send(32'd17, 32'd19, 1'b0, 4'h2, 64'd323);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {63'b0, bus.out_valid}, 64'd0);
    chk("midreset_r", bus.r, 64'd0);
    chk("midreset_in_ready", {63'b0, bus.in_ready}, 64'd1);
    sb.delete();
    #1 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("postreset_no_stale", {63'b0, bus.out_valid}, 64'd0);
    end
    @(posedge clk); #1;

    send(32'd6, 32'hFFFFFFF9, 1'b1, 4'h3, 64'hFFFFFFFFFFFFFFD6);
    idle(4);
    chk("final_drained", sb.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200us, expected finish");
    $fatal(1, "timeout");
  end
endmodule
